// File: rtl/oob_link_if.sv
// OOB engine handshake bundle between the link manager and the OOB sequencer.
// master = link manager side, slave = OOB engine side.
interface oob_link_if;
    logic oob_start;
    logic cominit_allow;
    logic oob_busy;
    logic link_up;
    logic link_down;
    logic oob_error;
    logic oob_silence;
    logic cominit_req;

    modport master (
        output oob_start, cominit_allow,
        input  oob_busy, link_up, link_down, oob_error, oob_silence, cominit_req
    );

    modport slave (
        input  oob_start, cominit_allow,
        output oob_busy, link_up, link_down, oob_error, oob_silence, cominit_req
    );
endinterface

// File: rtl/oob_link_mgr.sv
// SATA OOB link manager: attempt/backoff/retry FSM with offline and COMRESET control.
// Define OOB_LINK_STATS_EN to build the link-up / error statistics counters.
module oob_link_mgr #(
    parameter int MAX_RETRIES = 3,
    parameter int RETRY_DELAY = 1024,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gtx_ready,
    input  logic                 rxbyteisaligned,
    input  logic                 set_offline,
    input  logic                 comreset_send,
    input  logic                 stats_clr,
    oob_link_if.master           oob,
    output logic                 phy_ready,
    output logic                 link_failed,
    output logic                 force_offline,
    output logic [3:0]           retry_cnt,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] link_up_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        BUSY    = 3'd2,
        LINKED  = 3'd3,
        BACKOFF = 3'd4,
        FAILED  = 3'd5,
        OFFLINE = 3'd6
    } st_t;

    st_t         st_q, st_d;
    logic [3:0]  retry_q, retry_d;
    logic [15:0] timer_q, timer_d;
    logic        start_q, failed_q, offline_q;
    logic        link_evt, err_evt;
    logic        active;

    assign active = (st_q == START) || (st_q == BUSY) ||
                    (st_q == LINKED) || (st_q == BACKOFF);

    always_comb begin
        st_d     = st_q;
        retry_d  = retry_q;
        timer_d  = timer_q;
        link_evt = 1'b0;
        err_evt  = 1'b0;
        if (comreset_send) begin
            st_d    = IDLE;
            retry_d = 4'd0;
        end else if (set_offline) begin
            st_d = OFFLINE;
        end else if (!gtx_ready && active) begin
            st_d    = IDLE;
            timer_d = 16'd0;
        end else begin
            case (st_q)
                IDLE: if (gtx_ready && !oob.oob_busy) st_d = START;
                START: st_d = BUSY;
                BUSY: begin
                    // link_up takes priority over a coincident error
                    if (oob.link_up) begin
                        st_d     = LINKED;
                        retry_d  = 4'd0;
                        link_evt = 1'b1;
                    end else if (oob.oob_error || oob.oob_silence) begin
                        err_evt = 1'b1;
                        if (retry_q == 4'(MAX_RETRIES)) begin
                            st_d = FAILED;
                        end else begin
                            st_d    = BACKOFF;
                            retry_d = retry_q + 4'd1;
                            timer_d = 16'(RETRY_DELAY - 1);
                        end
                    end
                end
                LINKED: begin
                    if (oob.link_down)        st_d = IDLE;
                    else if (oob.cominit_req) st_d = BUSY;
                end
                BACKOFF: begin
                    if (timer_q == 16'd0) st_d = IDLE;
                    else                  timer_d = timer_q - 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= IDLE;
            retry_q   <= 4'd0;
            timer_q   <= 16'd0;
            start_q   <= 1'b0;
            failed_q  <= 1'b0;
            offline_q <= 1'b0;
        end else begin
            st_q      <= st_d;
            retry_q   <= retry_d;
            timer_q   <= timer_d;
            start_q   <= (st_d == START);
            failed_q  <= (st_d == FAILED);
            offline_q <= (st_d == OFFLINE);
        end
    end

    // outputs are forced low while rst is held, before the registers settle
    assign state             = rst ? 3'd0 : st_q;
    assign retry_cnt         = rst ? 4'd0 : retry_q;
    assign oob.oob_start     = start_q & ~rst;
    assign link_failed       = failed_q & ~rst;
    assign force_offline     = offline_q & ~rst;
    assign phy_ready         = ~rst & (st_q == LINKED) & gtx_ready & rxbyteisaligned;
    assign oob.cominit_allow = ~rst & oob.cominit_req & (st_q == LINKED);

`ifdef OOB_LINK_STATS_EN
    logic [CNT_WIDTH-1:0] lu_q, er_q;

    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            lu_q <= '0;
            er_q <= '0;
        end else begin
            if (link_evt && !(&lu_q)) lu_q <= lu_q + 1'b1;
            if (err_evt && !(&er_q))  er_q <= er_q + 1'b1;
        end
    end

    assign link_up_cnt = rst ? '0 : lu_q;
    assign err_cnt     = rst ? '0 : er_q;
`else
    logic unused_stats;
    assign unused_stats = ^{stats_clr, link_evt, err_evt};
    assign link_up_cnt  = '0;
    assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_oob_link_mgr.sv
// Bench for oob_link_mgr: directed scenarios plus random traffic vs a rule-level model.
// Builds with or without OOB_LINK_STATS_EN.
module tb_oob_link_mgr;

    localparam int MAXR = 2;
    localparam int DLY  = 16;
    localparam int CW   = 2;
`ifdef OOB_LINK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int S_IDLE = 0, S_START = 1, S_BUSY = 2, S_LINKED = 3;
    localparam int S_BACKOFF = 4, S_FAILED = 5, S_OFFLINE = 6;

    logic clk = 1'b0;
    logic rst, gtx_ready, rxbyteisaligned, set_offline, comreset_send, stats_clr;
    logic phy_ready, link_failed, force_offline;
    logic [3:0] retry_cnt;
    logic [2:0] state;
    logic [CW-1:0] link_up_cnt, err_cnt;

    oob_link_if bus();

    oob_link_mgr #(.MAX_RETRIES(MAXR), .RETRY_DELAY(DLY), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .gtx_ready(gtx_ready),
        .rxbyteisaligned(rxbyteisaligned), .set_offline(set_offline),
        .comreset_send(comreset_send), .stats_clr(stats_clr), .oob(bus),
        .phy_ready(phy_ready), .link_failed(link_failed),
        .force_offline(force_offline), .retry_cnt(retry_cnt), .state(state),
        .link_up_cnt(link_up_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int m_st = 0, m_retry = 0, m_bo_left = 0, m_lu = 0, m_er = 0;
    int cyc = 0, b2b = 0;
    logic prev_start = 1'b0;

    task automatic check(string tag, int obs, int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: the spec's transition rules applied to plain integers.
    task automatic model_step();
        int  cmax = (1 << CW) - 1;
        bit  lu_ev = 0, er_ev = 0;
        bool_blk: begin end
        if (rst) begin
            m_st = S_IDLE; m_retry = 0; m_bo_left = 0; m_lu = 0; m_er = 0;
            return;
        end
        if (comreset_send) begin
            m_st = S_IDLE; m_retry = 0;
        end else if (set_offline) begin
            m_st = S_OFFLINE;
        end else if (!gtx_ready && m_st inside {S_START, S_BUSY, S_LINKED, S_BACKOFF}) begin
            m_st = S_IDLE;
        end else if (m_st == S_IDLE) begin
            if (gtx_ready && !bus.oob_busy) m_st = S_START;
        end else if (m_st == S_START) begin
            m_st = S_BUSY;
        end else if (m_st == S_BUSY) begin
            if (bus.link_up) begin
                m_st = S_LINKED; m_retry = 0; lu_ev = 1;
            end else if (bus.oob_error || bus.oob_silence) begin
                er_ev = 1;
                if (m_retry == MAXR) m_st = S_FAILED;
                else begin m_retry++; m_st = S_BACKOFF; m_bo_left = DLY; end
            end
        end else if (m_st == S_LINKED) begin
            if (bus.link_down) m_st = S_IDLE;
            else if (bus.cominit_req) m_st = S_BUSY;
        end else if (m_st == S_BACKOFF) begin
            m_bo_left--;
            if (m_bo_left == 0) m_st = S_IDLE;
        end
        if (stats_clr) begin
            m_lu = 0; m_er = 0;
        end else begin
            if (lu_ev && m_lu < cmax) m_lu++;
            if (er_ev && m_er < cmax) m_er++;
        end
    endtask

    function automatic int exp_phy();
        return (!rst && m_st == S_LINKED && gtx_ready && rxbyteisaligned) ? 1 : 0;
    endfunction

    function automatic int exp_ca();
        return (!rst && m_st == S_LINKED && bus.cominit_req) ? 1 : 0;
    endfunction

    task automatic compare();
        check("state", state, rst ? 0 : m_st);
        check("retry_cnt", retry_cnt, rst ? 0 : m_retry);
        check("oob_start", bus.oob_start, (!rst && m_st == S_START) ? 1 : 0);
        check("link_failed", link_failed, (!rst && m_st == S_FAILED) ? 1 : 0);
        check("force_offline", force_offline, (!rst && m_st == S_OFFLINE) ? 1 : 0);
        check("phy_ready", phy_ready, exp_phy());
        check("cominit_allow", bus.cominit_allow, exp_ca());
        check("link_up_cnt", link_up_cnt, STATS ? m_lu : 0);
        check("err_cnt", err_cnt, STATS ? m_er : 0);
        if (bus.oob_start && prev_start) b2b++;
        prev_start = bus.oob_start;
    endtask

    // Called at a falling edge with inputs already set; returns at the next one.
    task automatic cycle();
        #1;
        check("phy_ready_pre", phy_ready, exp_phy());
        check("cominit_allow_pre", bus.cominit_allow, exp_ca());
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        compare();
    endtask

    task automatic clear_pulses();
        set_offline = 0; comreset_send = 0; stats_clr = 0;
        bus.link_up = 0; bus.link_down = 0; bus.oob_error = 0;
        bus.oob_silence = 0; bus.cominit_req = 0; bus.oob_busy = 0;
    endtask

    task automatic wait_start(string tag, output int at);
        for (int i = 0; i < 40 && !bus.oob_start; i++) cycle();
        check(tag, bus.oob_start, 1);
        at = cyc;
    endtask

    initial begin
        int t_prev, t_now, cnt;
        bit seen;
        rst = 1; gtx_ready = 0; rxbyteisaligned = 0;
        clear_pulses();
        repeat (3) cycle();
        check("rst_state", state, 0);
        check("rst_start", bus.oob_start, 0);
        rst = 0;
        repeat (2) cycle();
        check("idle_no_gtx", state, S_IDLE);

        // bring-up, link_up beats a coincident error
        gtx_ready = 1; rxbyteisaligned = 1;
        cycle();
        check("gtx_to_start", bus.oob_start, 1);
        cycle();
        check("busy", state, S_BUSY);
        bus.link_up = 1; bus.oob_error = 1;
        cycle();
        clear_pulses();
        check("lu_wins", state, S_LINKED);
        check("lu_retry", retry_cnt, 0);
        check("lu_err_cnt", err_cnt, 0);
        check("phy_up", phy_ready, 1);

        // silence on every attempt until FAILED
        bus.link_down = 1;
        cycle();
        clear_pulses();
        t_prev = 0;
        for (int k = 1; k <= MAXR + 1; k++) begin
            wait_start("attempt_start", t_now);
            if (k > 1) check("start_gap", t_now - t_prev, DLY + 3);
            t_prev = t_now;
            cycle();
            bus.oob_silence = 1;
            cycle();
            clear_pulses();
            if (k <= MAXR) begin
                check("retry_step", retry_cnt, k);
                check("in_backoff", state, S_BACKOFF);
            end
        end
        check("failed_state", state, S_FAILED);
        check("failed_flag", link_failed, 1);
        check("failed_retry", retry_cnt, MAXR);
        repeat (5) cycle();
        check("failed_hold", link_failed, 1);
        comreset_send = 1;
        cycle();
        clear_pulses();
        cycle();
        check("comreset_start", bus.oob_start, 1);

        // offline from LINKED, then COMRESET
        cycle();
        bus.link_up = 1;
        cycle();
        clear_pulses();
        check("relinked", state, S_LINKED);
        set_offline = 1;
        cycle();
        clear_pulses();
        check("offline_force", force_offline, 1);
        check("offline_phy", phy_ready, 0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (bus.oob_start) cnt++;
        end
        check("offline_quiet", cnt, 0);
        comreset_send = 1;
        cycle();
        clear_pulses();
        seen = bus.oob_start;
        cycle();
        seen |= bus.oob_start;
        check("offline_restart", seen, 1);

        // reset three cycles into BACKOFF
        if (state == S_START) cycle();
        bus.oob_silence = 1;
        cycle();
        clear_pulses();
        repeat (3) cycle();
        check("pre_rst_backoff", state, S_BACKOFF);
        rst = 1;
        cycle();
        rst = 0;
        check("rst_bo_state", state, 0);
        check("rst_bo_retry", retry_cnt, 0);
        cycle();
        check("rst_restart", bus.oob_start, 1);

        // five link-ups: counter saturates, then clear
        cycle();
        bus.link_up = 1;
        cycle();
        clear_pulses();
        for (int i = 0; i < 4; i++) begin
            bus.cominit_req = 1;
            cycle();
            clear_pulses();
            bus.link_up = 1;
            cycle();
            clear_pulses();
        end
        check("lu_sat", link_up_cnt, STATS ? 3 : 0);
        stats_clr = 1;
        cycle();
        clear_pulses();
        check("lu_clr", link_up_cnt, 0);

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            rst             = ($urandom_range(199) == 0);
            comreset_send   = ($urandom_range(59) == 0);
            set_offline     = ($urandom_range(79) == 0);
            stats_clr       = ($urandom_range(49) == 0);
            gtx_ready       = ($urandom_range(19) != 0);
            rxbyteisaligned = ($urandom_range(4) != 0);
            bus.oob_busy    = ($urandom_range(4) == 0);
            bus.link_up     = ($urandom_range(9) == 0);
            bus.link_down   = ($urandom_range(19) == 0);
            bus.oob_error   = ($urandom_range(11) == 0);
            bus.oob_silence = ($urandom_range(11) == 0);
            bus.cominit_req = ($urandom_range(9) == 0);
            cycle();
        end

        check("no_back2back_start", b2b, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
